// File: rtl/lin_conv_stream.sv
// Streaming linear convolution Y = A * B: load both sequences, then one MAC per cycle per output.
// Define LIN_CONV_SAT_EN to saturate results to OW bits; otherwise results wrap.
module lin_conv_stream #(
   parameter int DW = 16,
   parameter int M  = 6,
   parameter int N  = 8,
   parameter int OW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_sel,
   input  logic signed [DW-1:0] s_data,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic signed [OW-1:0] y_data,
   output logic                 y_last,
   output logic                 busy
);

   localparam int AW  = 2*DW + 6;
   localparam int ACW = $clog2(M+1);
   localparam int BCW = $clog2(N+1);
   localparam int AIW = $clog2(M);
   localparam int BIW = $clog2(N);
   localparam int KW  = $clog2(M+N-1);

   localparam logic [ACW-1:0] A_FULL = ACW'(M);
   localparam logic [BCW-1:0] B_FULL = BCW'(N);
   localparam logic [KW-1:0]  K_LAST = KW'(M+N-2);

   typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

   state_t                state, state_nxt;
   logic [ACW-1:0]        a_cnt;
   logic [BCW-1:0]        b_cnt;
   logic [KW-1:0]         k;
   logic [ACW-1:0]        i;
   logic [ACW-1:0]        hi_k;
   logic signed [AW-1:0]  acc;
   logic signed [2*DW-1:0] prod;
   logic signed [OW-1:0]  y_conv;
   logic                  a_full, b_full, k_last, mac_en;

   logic signed [DW-1:0]  a_mem [M];
   logic signed [DW-1:0]  b_mem [N];

   // First and last A index contributing to output k.
   function automatic logic [ACW-1:0] lo_of(input logic [KW-1:0] kk);
      return (kk >= KW'(N-1)) ? ACW'(kk - KW'(N-1)) : '0;
   endfunction

   function automatic logic [ACW-1:0] hi_of(input logic [KW-1:0] kk);
      return (kk < KW'(M-1)) ? ACW'(kk) : ACW'(M-1);
   endfunction

   assign a_full = (a_cnt == A_FULL);
   assign b_full = (b_cnt == B_FULL);
   assign k_last = (k == K_LAST);
   assign hi_k   = hi_of(k);
   assign mac_en = (state == CALC) && (i <= hi_k);
   assign prod   = a_mem[AIW'(i)] * b_mem[BIW'(k - KW'(i))];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      y_valid   = 1'b0;
      y_last    = 1'b0;
      busy      = 1'b1;
      unique case (state)
         LOAD: begin
            busy    = 1'b0;
            s_ready = s_sel ? (b_cnt < B_FULL) : (a_cnt < A_FULL);
            if (a_full && b_full) state_nxt = CALC;
         end
         CALC: begin
            if (!mac_en) state_nxt = OUT;
         end
         OUT: begin
            y_valid = 1'b1;
            y_last  = k_last;
            if (y_ready) state_nxt = k_last ? LOAD : CALC;
         end
         default: state_nxt = LOAD;
      endcase
   end

`ifdef LIN_CONV_SAT_EN
   localparam logic signed [AW-1:0] OMAX = $signed({{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}});
   localparam logic signed [AW-1:0] OMIN = $signed({{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}});

   always_comb begin
      y_conv = OW'(acc);
      if (acc > OMAX)      y_conv = OW'(OMAX);
      else if (acc < OMIN) y_conv = OW'(OMIN);
   end
`else
   always_comb begin
      y_conv = acc[OW-1:0];
   end
`endif

   // The extra CALC cycle after the last term registers the converted result into y_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_cnt  <= '0;
         b_cnt  <= '0;
         k      <= '0;
         i      <= '0;
         acc    <= '0;
         y_data <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (s_valid && s_ready) begin
                  if (s_sel) b_cnt <= b_cnt + BCW'(1);
                  else       a_cnt <= a_cnt + ACW'(1);
               end
               if (a_full && b_full) begin
                  k   <= '0;
                  i   <= '0;
                  acc <= '0;
               end
            end
            CALC: begin
               if (mac_en) begin
                  acc <= acc + $signed({{(AW-2*DW){prod[2*DW-1]}}, prod});
                  i   <= i + ACW'(1);
               end else begin
                  y_data <= y_conv;
               end
            end
            OUT: begin
               if (y_ready) begin
                  acc <= '0;
                  if (k_last) begin
                     a_cnt <= '0;
                     b_cnt <= '0;
                     k     <= '0;
                  end else begin
                     k <= k + KW'(1);
                     i <= lo_of(k + KW'(1));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sample storage has no reset; the counts alone decide what is valid.
   always_ff @(posedge clk) begin
      if (s_valid && s_ready) begin
         if (s_sel) b_mem[BIW'(b_cnt)] <= s_data;
         else       a_mem[AIW'(a_cnt)] <= s_data;
      end
   end

endmodule

// File: tb/tb_lin_conv_stream.sv
// Scoreboard bench for lin_conv_stream: expected results come from a direct convolution sum.
module tb_lin_conv_stream;
   localparam int DW = 16;
   localparam int M  = 6;
   localparam int N  = 8;
   localparam int OW = 32;
   localparam int NY = M + N - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 s_valid;
   logic                 s_ready;
   logic                 s_sel;
   logic signed [DW-1:0] s_data;
   logic                 y_valid;
   logic                 y_ready = 1'b0;
   logic signed [OW-1:0] y_data;
   logic                 y_last;
   logic                 busy;

   typedef struct packed {logic [OW-1:0] data; logic last;} exp_t;
   typedef logic signed [DW-1:0] a_arr_t [M];
   typedef logic signed [DW-1:0] b_arr_t [N];

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_pop  = 0;
   bit   rdy_rand = 1'b1;
   logic rdy_manual = 1'b1;

   lin_conv_stream #(.DW(DW), .M(M), .N(N), .OW(OW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel),
      .s_data(s_data), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .y_last(y_last), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, got no event, expected one", name);
   endtask

   always @(posedge clk) begin
      #1;
      y_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_manual;
   end

   // Monitor: every accepted result is compared with the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && y_valid && y_ready) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_y: got %0h expected no result", y_data);
         end else begin
            e = exp_q.pop_front();
            check("y_data", $unsigned(y_data), e.data);
            check("y_last", y_last, e.last);
            check("busy_out", busy, 1);
         end
         n_pop++;
      end
   end

   function automatic logic [OW-1:0] to_out(input longint s);
      longint v;
      v = s;
`ifdef LIN_CONV_SAT_EN
      if (v > (longint'(1) <<< (OW-1)) - 1) v = (longint'(1) <<< (OW-1)) - 1;
      else if (v < -(longint'(1) <<< (OW-1))) v = -(longint'(1) <<< (OW-1));
`endif
      return v[OW-1:0];
   endfunction

   // Reference model: Y[k] = sum over all i,j with i+j=k of A[i]*B[j].
   task automatic push_model(input a_arr_t a, input b_arr_t b);
      exp_t e;
      for (int kk = 0; kk < NY; kk++) begin
         longint s = 0;
         for (int ii = 0; ii < M; ii++) begin
            int jj = kk - ii;
            if (jj >= 0 && jj < N) s += longint'(a[ii]) * longint'(b[jj]);
         end
         e.data = to_out(s);
         e.last = (kk == NY - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_ramp_table();
      int   ref_y [NY] = '{1, 3, 6, 10, 15, 21, 21, 21, 20, 18, 15, 11, 6};
      exp_t e;
      for (int kk = 0; kk < NY; kk++) begin
         e.data = OW'(ref_y[kk]);
         e.last = (kk == NY - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send(input logic sel, input logic signed [DW-1:0] d);
      int t = 0;
      s_valid = 1'b1;
      s_sel   = sel;
      s_data  = d;
      @(negedge clk);
      while (!s_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) fail_timeout("s_ready");
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   // mode 0: strict A,B alternation; mode 1: random order with idle gaps.
   task automatic load_frame(input a_arr_t a, input b_arr_t b, input int mode, input bit probe);
      int ia = 0;
      int ib = 0;
      bit probed = 1'b0;
      while (ia < M || ib < N) begin
         logic sel;
         if (probe && !probed && ia == M && ib < N) begin
            probed  = 1'b1;
            s_valid = 1'b1;
            s_sel   = 1'b0;
            s_data  = 16'sd99;
            @(negedge clk);
            check("full_a_ready", s_ready, 0);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
         end
         if (mode == 0)      sel = (ia < M && (ia <= ib || ib >= N)) ? 1'b0 : 1'b1;
         else if (ia >= M)   sel = 1'b1;
         else if (ib >= N)   sel = 1'b0;
         else                sel = 1'($urandom_range(0, 1));
         if (mode == 1 && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         if (sel) begin
            send(1'b1, b[ib]);
            ib++;
         end else begin
            send(1'b0, a[ia]);
            ia++;
         end
      end
      @(negedge clk);
      @(negedge clk);
      check("busy_calc", busy, 1);
      check("s_ready_calc", s_ready, 0);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) fail_timeout("drain");
      @(posedge clk);
      #1;
      check("busy_idle", busy, 0);
      check("y_valid_idle", y_valid, 0);
   endtask

   task automatic wait_pops(input int target);
      int t = 0;
      while (n_pop < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (n_pop < target) fail_timeout("pops");
   endtask

   task automatic wait_valid();
      int t = 0;
      @(negedge clk);
      while (!y_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!y_valid) fail_timeout("y_valid");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, s_ready, 1);
      check({tag, "_y_valid"}, y_valid, 0);
      check({tag, "_y_last"},  y_last, 0);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_y_data"},  $unsigned(y_data), 0);
   endtask

   initial begin
      a_arr_t ra, xa;
      b_arr_t ob, xb;
      bit     saw;

      for (int i = 0; i < M; i++) ra[i] = DW'(i + 1);
      for (int j = 0; j < N; j++) ob[j] = 16'sd1;

      rst = 1'b1; s_valid = 1'b0; s_sel = 1'b0; s_data = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Ramp against ones, alternating, with an offer to the full A buffer.
      push_ramp_table();
      load_frame(ra, ob, 0, 1'b1);
      wait_drain();

      // Consumer stall on Y[3].
      rdy_rand = 1'b0; rdy_manual = 1'b1; n_pop = 0;
      push_ramp_table();
      load_frame(ra, ob, 1, 1'b0);
      wait_pops(3);
      rdy_manual = 1'b0;
      wait_valid();
      for (int c = 0; c < 5; c++) begin
         check("stall_valid", y_valid, 1);
         check("stall_data", $unsigned(y_data), 10);
         check("stall_last", y_last, 0);
         @(negedge clk);
      end
      check("stall_no_advance", n_pop, 3);
      rdy_manual = 1'b1;
      wait_drain();
      rdy_rand = 1'b1;

      // Random data frames.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < M; i++) xa[i] = DW'($urandom);
         for (int j = 0; j < N; j++) xb[j] = DW'($urandom);
         push_model(xa, xb);
         load_frame(xa, xb, 1, 1'b0);
         wait_drain();
      end

      // Most negative inputs overflow the OW range.
      for (int i = 0; i < M; i++) xa[i] = 16'sh8000;
      for (int j = 0; j < N; j++) xb[j] = 16'sh8000;
      push_model(xa, xb);
      load_frame(xa, xb, 1, 1'b0);
      wait_drain();

      // Reset while Y[4] is presented, then a full reload.
      rdy_rand = 1'b0; rdy_manual = 1'b1; n_pop = 0;
      push_ramp_table();
      load_frame(ra, ob, 0, 1'b0);
      wait_pops(4);
      rdy_manual = 1'b0;
      wait_valid();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      rdy_manual = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (y_valid || busy) saw = 1'b1;
      end
      check("no_valid_after_rst", saw, 0);
      rdy_rand = 1'b1;
      for (int i = 0; i < M; i++) xa[i] = 16'sd2;
      for (int j = 0; j < N; j++) xb[j] = 16'sd3;
      push_model(xa, xb);
      load_frame(xa, xb, 1, 1'b0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
